// File: rtl/pipe_skid_buffer_if.sv
// Ready/valid handshake bundle for the two-entry pipeline skid stage.
// The producer/consumer side (tb or neighbouring stages) uses master; the stage uses slave.
interface pipe_skid_buffer_if #(
  parameter int SIZE = 32
);
  logic            in_valid;
  logic [SIZE-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic [SIZE-1:0] out_data;
  logic            out_ready;
  logic [1:0]      count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry (main + skid) ready/valid stage register between pipeline stages.
// in_ready comes purely from registered state, so no out_ready -> in_ready combinational path exists.
module pipe_skid_buffer #(
  parameter int SIZE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  pipe_skid_buffer_if.slave  bus
);

  // Encoding equals occupancy, so count is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_main;
  logic [SIZE-1:0] r_skid;
  logic            w_accept;
  logic            w_drain;

  assign bus.in_ready  = (r_state != FULL);
  assign bus.out_valid = (r_state != EMPTY);
  assign bus.out_data  = r_main;
  assign bus.count     = r_state;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_drain  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main  <= bus.in_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          // A drain with no accept leaves main stale; out_valid=0 marks it.
          if (w_accept && w_drain) begin
            r_main <= bus.in_data;
          end else if (w_accept) begin
            r_skid  <= bus.in_data;
            r_state <= FULL;
          end else if (w_drain) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_drain) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed bench for pipe_skid_buffer: a queue-based occupancy model checked every cycle,
// plus literal expectations pinning the key scenarios.
module tb_pipe_skid_buffer;
  localparam int SIZE = 32;

  logic clk;
  logic rst;
  logic flush;

  pipe_skid_buffer_if #(.SIZE(SIZE)) bus ();

  pipe_skid_buffer #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  task automatic check(input string name, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of depth 2; out_data shows the head, or the
  // last presented word once empty (zero after reset/flush).
  logic [SIZE-1:0] m_q[$];
  logic [SIZE-1:0] m_main;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_main = '0;
    end else begin
      bit acc, drn;
      acc = bus.in_valid && (m_q.size() < 2);
      drn = bus.out_ready && (m_q.size() > 0);
      if (flush) begin
        m_q.delete();
        m_main = '0;
      end else begin
        if (drn) void'(m_q.pop_front());
        if (acc) m_q.push_back(bus.in_data);
        if (m_q.size() > 0) m_main = m_q[0];
      end
    end
  end

  always @(negedge clk) begin
    check("model_out_valid", {31'd0, bus.out_valid}, {31'd0, m_q.size() > 0});
    check("model_in_ready",  {31'd0, bus.in_ready},  {31'd0, m_q.size() < 2});
    check("model_count",     {30'd0, bus.count},     SIZE'(m_q.size()));
    check("model_out_data",  bus.out_data,           m_main);
  end

  // Drive one cycle: inputs set after a falling edge, held across the rising edge.
  task automatic cyc(input logic iv, input logic [SIZE-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Streaming with out_ready held high.
    cyc(1'b1, 32'h11, 1'b1, 1'b0);
    check("stream_0x11", bus.out_data, 32'h11);
    cyc(1'b1, 32'h22, 1'b1, 1'b0);
    check("stream_0x22", bus.out_data, 32'h22);
    check("stream_count", {30'd0, bus.count}, 32'd1);
    cyc(1'b1, 32'h33, 1'b1, 1'b0);
    check("stream_0x33", bus.out_data, 32'h33);
    check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("stream_empty", {30'd0, bus.count}, 32'd0);

    // Stall fill, third push held off.
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    check("fill_count", {30'd0, bus.count}, 32'd2);
    check("fill_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    check("fill_stable_A", bus.out_data, 32'hA);
    check("fill_count_hold", {30'd0, bus.count}, 32'd2);

    // Release: A drains, then B, then C (accepted once space opens).
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    check("release_B", bus.out_data, 32'hB);
    cyc(1'b1, 32'hC, 1'b1, 1'b0);
    check("release_C", bus.out_data, 32'hC);
    check("release_count", {30'd0, bus.count}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("release_empty", {31'd0, bus.out_valid}, 32'd0);

    // Simultaneous accept and drain in ONE.
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    cyc(1'b1, 32'h6, 1'b1, 1'b0);
    check("accdrn_data", bus.out_data, 32'h6);
    check("accdrn_count", {30'd0, bus.count}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while FULL with accept and drain requested.
    cyc(1'b1, 32'h7, 1'b0, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0);
    cyc(1'b1, 32'h9, 1'b1, 1'b1);
    check("flush_count", {30'd0, bus.count}, 32'd0);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("flush_out_data", bus.out_data, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush_stays_empty", {31'd0, bus.out_valid}, 32'd0);

    // Data garbage with in_valid low must not be captured.
    cyc(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("idle_no_capture", bus.out_data, 32'h0);

    // Asynchronous reset mid-stream while FULL.
    cyc(1'b1, 32'hD, 1'b0, 1'b0);
    cyc(1'b1, 32'hE, 1'b0, 1'b0);
    check("prerst_count", {30'd0, bus.count}, 32'd2);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_count", {30'd0, bus.count}, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("arst_out_data", bus.out_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 32'hF, 1'b1, 1'b0);
    check("post_rst_F", bus.out_data, 32'hF);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1);
  end
endmodule
